// File: rtl/max7219_pkg.sv
`default_nettype none
// -----------------------------------------------------------------------------
// max7219_pkg : MAX7219 register address map, receiver FSM states, code-B table.
// Rev 1.0
// -----------------------------------------------------------------------------
package max7219_pkg;

  localparam logic [3:0] NOOP         = 4'h0;
  localparam logic [3:0] DIGIT0       = 4'h1;
  localparam logic [3:0] DIGIT1       = 4'h2;
  localparam logic [3:0] DIGIT2       = 4'h3;
  localparam logic [3:0] DIGIT3       = 4'h4;
  localparam logic [3:0] DIGIT4       = 4'h5;
  localparam logic [3:0] DIGIT5       = 4'h6;
  localparam logic [3:0] DIGIT6       = 4'h7;
  localparam logic [3:0] DIGIT7       = 4'h8;
  localparam logic [3:0] DECODE_MODE  = 4'h9;
  localparam logic [3:0] INTENSITY    = 4'hA;
  localparam logic [3:0] SCAN_LIMIT   = 4'hB;
  localparam logic [3:0] SHUTDOWN     = 4'hC;
  localparam logic [3:0] DISPLAY_TEST = 4'hF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  // Segments A..G in bits 6..0; DP is handled by the caller.
  function automatic logic [6:0] code_b_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'h7E;
      4'h1:    seg = 7'h30;
      4'h2:    seg = 7'h6D;
      4'h3:    seg = 7'h79;
      4'h4:    seg = 7'h33;
      4'h5:    seg = 7'h5B;
      4'h6:    seg = 7'h5F;
      4'h7:    seg = 7'h70;
      4'h8:    seg = 7'h7F;
      4'h9:    seg = 7'h7B;
      4'hA:    seg = 7'h01;
      4'hB:    seg = 7'h4F;
      4'hC:    seg = 7'h37;
      4'hD:    seg = 7'h0E;
      4'hE:    seg = 7'h67;
      default: seg = 7'h00;
    endcase
    return seg;
  endfunction

endpackage
`default_nettype wire

// File: rtl/max7219_sync.sv
`default_nettype none
// -----------------------------------------------------------------------------
// max7219_sync : 2-flop synchroniser with registered-history rise/fall detect.
// Rev 1.0
// -----------------------------------------------------------------------------
module max7219_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic async_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [1:0] sync_q, sync_d;
  logic       prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[0], async_in};
    prev_d = sync_q[1];
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_q <= 2'b00;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign level = sync_q[1];
  assign rise  = sync_q[1] & ~prev_q;
  assign fall  = ~sync_q[1] & prev_q;

endmodule
`default_nettype wire

// File: rtl/max7219_rx.sv
`default_nettype none
// -----------------------------------------------------------------------------
// max7219_rx : daisy-chained MAX7219 SPI receiver with shadow register file.
// Optional MAX7219_RX_SEG_DECODE_EN adds a registered segment output. Rev 1.0
// -----------------------------------------------------------------------------
module max7219_rx
  import max7219_pkg::*;
#(
  parameter int DEVICES = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   spi_clk,
  input  logic                   spi_din,
  input  logic                   spi_load,
  output logic [DEVICES*64-1:0]  digits,
  output logic [DEVICES*8-1:0]   decode_mode,
  output logic [DEVICES*4-1:0]   intensity,
  output logic [DEVICES*3-1:0]   scan_limit,
  output logic [DEVICES-1:0]     shutdown_n,
  output logic [DEVICES-1:0]     display_test,
  output logic                   frame_valid,
  output logic                   frame_err
`ifdef MAX7219_RX_SEG_DECODE_EN
  ,
  output logic [DEVICES*64-1:0]  seg
`endif
);

  localparam int FRAME_BITS = 16 * DEVICES;
  localparam int CNT_W      = $clog2(FRAME_BITS + 2);

  logic clk_rise, clk_fall, clk_level;
  logic din_level, din_rise, din_fall;
  logic load_rise, load_fall, load_level;

  max7219_sync u_sync_clk (
    .clk(clk), .reset_n(reset_n), .async_in(spi_clk),
    .level(clk_level), .rise(clk_rise), .fall(clk_fall)
  );
  max7219_sync u_sync_din (
    .clk(clk), .reset_n(reset_n), .async_in(spi_din),
    .level(din_level), .rise(din_rise), .fall(din_fall)
  );
  max7219_sync u_sync_load (
    .clk(clk), .reset_n(reset_n), .async_in(spi_load),
    .level(load_level), .rise(load_rise), .fall(load_fall)
  );

  logic unused_sync;
  assign unused_sync = &{1'b0, clk_fall, clk_level, din_rise, din_fall, load_level};

  state_t                  state_q, state_d;
  logic [FRAME_BITS-1:0]   shift_q, shift_d;
  logic [CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DEVICES*64-1:0]   digits_q, digits_d;
  logic [DEVICES*8-1:0]    decode_mode_q, decode_mode_d;
  logic [DEVICES*4-1:0]    intensity_q, intensity_d;
  logic [DEVICES*3-1:0]    scan_limit_q, scan_limit_d;
  logic [DEVICES-1:0]      shutdown_n_q, shutdown_n_d;
  logic [DEVICES-1:0]      display_test_q, display_test_d;
  logic                    frame_valid_q, frame_valid_d;
  logic                    frame_err_q, frame_err_d;
  logic [3:0]              addr;
  logic [7:0]              data;

  always_comb begin
    state_d        = state_q;
    shift_d        = shift_q;
    bit_cnt_d      = bit_cnt_q;
    digits_d       = digits_q;
    decode_mode_d  = decode_mode_q;
    intensity_d    = intensity_q;
    scan_limit_d   = scan_limit_q;
    shutdown_n_d   = shutdown_n_q;
    display_test_d = display_test_q;
    frame_valid_d  = 1'b0;
    frame_err_d    = 1'b0;
    addr           = 4'h0;
    data           = 8'h00;

    case (state_q)
      IDLE: begin
        if (load_fall) begin
          bit_cnt_d = '0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        // A load edge in the same cycle as a clock edge ends the frame first.
        if (load_rise) begin
          state_d = COMMIT;
        end else if (clk_rise) begin
          shift_d = {shift_q[FRAME_BITS-2:0], din_level};
          if (bit_cnt_q != CNT_W'(FRAME_BITS + 1)) begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      COMMIT: begin
        state_d = IDLE;
        if (bit_cnt_q == CNT_W'(FRAME_BITS)) begin
          frame_valid_d = 1'b1;
          for (int d = 0; d < DEVICES; d++) begin
            addr = shift_q[d*16+8 +: 4];
            data = shift_q[d*16 +: 8];
            for (int k = 0; k < 8; k++) begin
              if (addr == DIGIT0 + 4'(k)) begin
                digits_d[d*64+k*8 +: 8] = data;
              end
            end
            case (addr)
              DECODE_MODE:  decode_mode_d[d*8 +: 8] = data;
              INTENSITY:    intensity_d[d*4 +: 4]   = data[3:0];
              SCAN_LIMIT:   scan_limit_d[d*3 +: 3]  = data[2:0];
              SHUTDOWN:     shutdown_n_d[d]         = data[0];
              DISPLAY_TEST: display_test_d[d]       = data[0];
              default: ;
            endcase
          end
        end else begin
          frame_err_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      shift_q        <= '0;
      bit_cnt_q      <= '0;
      digits_q       <= '0;
      decode_mode_q  <= '0;
      intensity_q    <= '0;
      scan_limit_q   <= '0;
      shutdown_n_q   <= '0;
      display_test_q <= '0;
      frame_valid_q  <= 1'b0;
      frame_err_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      shift_q        <= shift_d;
      bit_cnt_q      <= bit_cnt_d;
      digits_q       <= digits_d;
      decode_mode_q  <= decode_mode_d;
      intensity_q    <= intensity_d;
      scan_limit_q   <= scan_limit_d;
      shutdown_n_q   <= shutdown_n_d;
      display_test_q <= display_test_d;
      frame_valid_q  <= frame_valid_d;
      frame_err_q    <= frame_err_d;
    end
  end

  assign digits       = digits_q;
  assign decode_mode  = decode_mode_q;
  assign intensity    = intensity_q;
  assign scan_limit   = scan_limit_q;
  assign shutdown_n   = shutdown_n_q;
  assign display_test = display_test_q;
  assign frame_valid  = frame_valid_q;
  assign frame_err    = frame_err_q;

`ifdef MAX7219_RX_SEG_DECODE_EN
  logic [DEVICES*64-1:0] seg_q, seg_d;

  // Display test overrides shutdown, which overrides decoding.
  always_comb begin
    seg_d = '0;
    for (int d = 0; d < DEVICES; d++) begin
      for (int k = 0; k < 8; k++) begin
        if (display_test_q[d]) begin
          seg_d[d*64+k*8 +: 8] = 8'hFF;
        end else if (!shutdown_n_q[d]) begin
          seg_d[d*64+k*8 +: 8] = 8'h00;
        end else if (decode_mode_q[d*8+k]) begin
          seg_d[d*64+k*8 +: 8] = {digits_q[d*64+k*8+7], code_b_seg(digits_q[d*64+k*8 +: 4])};
        end else begin
          seg_d[d*64+k*8 +: 8] = digits_q[d*64+k*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      seg_q <= '0;
    end else begin
      seg_q <= seg_d;
    end
  end

  assign seg = seg_q;
`endif

endmodule
`default_nettype wire

// File: doc/max7219_rx.md
Name: max7219_rx

Overview:
- SPI receiver end of the MAX7219 display link; the counterpart of the MAX7219 transmitter that drives SPI_DO/SPI_CLK/SPI_CS.
- Deserialises a daisy-chained MAX7219 stream (DIN/CLK/LOAD) and decodes each device's 16-bit command into a shadow register file: 8 digits plus the control registers.
- Used as a loopback checker for the display path and as an on-FPGA display model that feeds local LED/7-segment drive.

Parameters:
- DEVICES, 2, number of chained MAX7219 devices modelled (1..8).
- FRAME_BITS, 16*DEVICES, derived (localparam); bits per complete load frame.

Ports:
- clk  in  1  system clock; must run at least 4x spi_clk.
- reset_n  in  1  synchronous, active-low reset.
- spi_clk  in  1  serial clock, asynchronous to clk.
- spi_din  in  1  serial data, MSB first per device word.
- spi_load  in  1  LOAD/CS; low while shifting, rising edge latches the frame.
- digits  out  DEVICES*64  raw digit registers; device d, digit k at [d*64+k*8 +: 8].
- decode_mode  out  DEVICES*8  per-digit code-B enable.
- intensity  out  DEVICES*4  brightness 0..15.
- scan_limit  out  DEVICES*3  highest scanned digit.
- shutdown_n  out  DEVICES  1 = normal operation.
- display_test  out  DEVICES  1 = all segments on.
- frame_valid  out  1  one-cycle pulse when a frame is committed.
- frame_err  out  1  one-cycle pulse when a frame is discarded.

Behaviour:
- Reset (reset_n low at a clk edge) clears all outputs, the shift register, the bit counter and the synchronisers. Every register output is 0, so shutdown_n=0 (shutdown mode). FSM goes to IDLE.
- Synchronisation: spi_clk, spi_din and spi_load each pass through 2 flops, then a 1-flop edge detect.
- FSM:
  - IDLE: wait for spi_load low; on its falling edge clear bit_cnt and go to SHIFT.
  - SHIFT: on each spi_clk rising edge, shift = {shift[FRAME_BITS-2:0], din} and bit_cnt += 1. bit_cnt saturates at FRAME_BITS+1. On spi_load rising edge go to COMMIT.
  - COMMIT: one cycle. If bit_cnt == FRAME_BITS, apply every device word and pulse frame_valid. Otherwise change nothing and pulse frame_err. Then return to IDLE.
- Chain order: shift[15:0] is device 0 (nearest DIN, last word sent); shift[d*16 +: 16] is device d.
- Word decode: addr = w[11:8], data = w[7:0]; w[15:12] ignored.
  - 0x0: no-op.
  - 0x1..0x8: digit addr-1 <= data.
  - 0x9: decode_mode <= data.
  - 0xA: intensity <= data[3:0].
  - 0xB: scan_limit <= data[2:0].
  - 0xC: shutdown_n <= data[0].
  - 0xF: display_test <= data[0].
  - 0xD, 0xE: ignored.
- All devices update in the same COMMIT cycle.
- Latency: pin-level spi_load rise to updated outputs and frame_valid is 4 clk cycles (2 sync + edge + COMMIT).
- Same-cycle spi_clk rise and spi_load rise: the load edge wins and that bit is discarded (not shifted, not counted).
- spi_clk edges while in IDLE are ignored.
- More than FRAME_BITS bits: the shift register keeps the last FRAME_BITS bits, bit_cnt saturates, and the frame is discarded with frame_err.
- Reset asserted mid-SHIFT: the partial frame is lost and no pulse is produced.

Optional Feature:
- Macro MAX7219_RX_SEG_DECODE_EN.
- Defined: adds output seg [DEVICES*64-1:0], registered one cycle after digits/decode_mode change. Segment order per byte is DP,A,B,C,D,E,F,G (bit7..0).
  - Digits whose decode_mode bit is set use code B on data[3:0]: 0-9, A='-', B=E, C=H, D=L, E=P, F=blank. DP comes from data[7].
  - Other digits pass through raw.
  - display_test=1 forces all 0xFF; shutdown_n=0 forces 0x00. display_test wins over shutdown.
- Undefined: seg port and decode logic are absent.

Decomposition:
- Package max7219_pkg holds:
  - the address constants (NOOP, DIGIT0..7, DECODE_MODE, INTENSITY, SCAN_LIMIT, SHUTDOWN, DISPLAY_TEST);
  - the FSM state enum (IDLE, SHIFT, COMMIT);
  - the code-B segment lookup function.
- Sub-module max7219_sync: 2-flop synchroniser plus rise/fall edge outputs, same clk/reset_n. Instantiated 3 times.

Test Plan:
- Reset: hold reset_n low 5 cycles -> all outputs 0, shutdown_n=2'b00, no pulses.
- Basic frame, DEVICES=2: send words 0x0C01 then 0x0A07, 32 bits, load rises -> shutdown_n=2'b10, intensity=8'h07, frame_valid high for exactly 1 cycle, 4 cycles after the load rise.
- Digit write: send 0x0812 then 0x0134 -> device1 digit7=0x12, device0 digit0=0x34; all other digits unchanged.
- Short frame: 31 bits then load rise -> frame_err pulse, registers unchanged. Long frame of 33 bits -> frame_err pulse.
- Collision: spi_clk rise aligned with spi_load rise after 32 bits -> bit discarded, frame commits with the first 32 bits.
- MAX7219_RX_SEG_DECODE_EN: decode_mode dev0=0xFF, shutdown_n dev0=1, digit0 dev0=0x85 -> seg byte 0xDB ('5' plus DP). Then display_test=1 -> 0xFF.
